// File: rtl/vx_ttu_ctrl_pkg.sv
// vx_ttu_ctrl_pkg: shared TTU state encoding and warp-wrap helper
package vx_ttu_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        SWAP    = 3'd2,
        RUN     = 3'd3,
        RESTORE = 3'd4,
        ABORT   = 3'd5
    } ttu_state_e;

    function automatic int next_warp(input int w, input int n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction
endpackage

// File: rtl/vx_ttu_ctrl_if.sv
// vx_ttu_ctrl_if: TTU master/slave link (state, ISR_PC, wid, tid, saved context out; drain/thread status and ISR_done in)
interface vx_ttu_ctrl_if #(
    parameter int XLEN        = 32,
    parameter int NUM_THREADS = 4,
    parameter int NW_WIDTH    = 2,
    parameter int NT_WIDTH    = 2
);
    import vx_ttu_ctrl_pkg::*;
    ttu_state_e             state;
    logic [XLEN-1:0]        ISR_PC;
    logic [NW_WIDTH-1:0]    wid;
    logic [NT_WIDTH-1:0]    tid;
    logic                   pipeline_drained;
    logic                   thread_found;
    logic [NUM_THREADS-1:0] current_thread_mask;
    logic [XLEN-1:0]        current_PC;
    logic                   ISR_done;
    logic [NUM_THREADS-1:0] interrupted_thread_mask;
    logic [XLEN-1:0]        interrupted_PC;

    modport master (
        output state, ISR_PC, wid, tid, interrupted_thread_mask, interrupted_PC,
        input  pipeline_drained, thread_found, current_thread_mask, current_PC, ISR_done
    );
    modport slave (
        input  state, ISR_PC, wid, tid, interrupted_thread_mask, interrupted_PC,
        output pipeline_drained, thread_found, current_thread_mask, current_PC, ISR_done
    );
endinterface

// File: rtl/vx_ttu_ctrl_lzc.sv
// vx_ttu_ctrl_lzc: lowest-set-bit index encoder (in -> idx, valid when any bit set)
module vx_ttu_ctrl_lzc #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         valid
);
    // Scan from the top so the lowest set bit is the last (winning) write.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (in[i]) idx = W'(i);
    end

    assign valid = |in;
endmodule

// File: rtl/vx_ttu_ctrl.sv
// vx_ttu_ctrl: TTU master controller -- accepts an ISR request, finds and drains a victim warp, swaps in the ISR, restores context
// Ports: clk, reset_n (async, active-low); irq_valid/irq_isr_pc/irq_ready request handshake;
//        irq_done / irq_err one-cycle result pulses; ttu master modport towards the scheduler slave.
module vx_ttu_ctrl
    import vx_ttu_ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int NUM_WARPS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CNT_W         = 11,
    parameter int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NT_WIDTH      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            irq_valid,
    input  logic [XLEN-1:0] irq_isr_pc,
    output logic            irq_ready,
    output logic            irq_done,
    output logic            irq_err,
    vx_ttu_ctrl_if.master   ttu
);
    ttu_state_e             state_q, state_d;
    logic [XLEN-1:0]        isr_pc_q, isr_pc_d;
    logic [NW_WIDTH-1:0]    wid_q, wid_d;
    logic [NT_WIDTH-1:0]    tid_q, tid_d;
    logic [NUM_THREADS-1:0] mask_q, mask_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [NW_WIDTH-1:0]    rr_q, rr_d;
    logic [NW_WIDTH-1:0]    att_q, att_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NT_WIDTH-1:0]    low_idx;
    logic                   low_valid;
    logic                   hit, miss, last, timeout;
    logic [NW_WIDTH-1:0]    wid_nxt;

    vx_ttu_ctrl_lzc #(.N(NUM_THREADS), .W(NT_WIDTH)) u_lzc (
        .in    (ttu.current_thread_mask),
        .idx   (low_idx),
        .valid (low_valid)
    );

    // An all-zero mask with thread_found is a miss, so hit also needs a set bit.
    assign hit     = ttu.pipeline_drained & ttu.thread_found & low_valid;
    assign miss    = ttu.pipeline_drained & ~hit;
    assign last    = att_q == NW_WIDTH'(NUM_WARPS - 1);
    assign timeout = cnt_q == CNT_W'(DRAIN_TIMEOUT - 1);
    assign wid_nxt = NW_WIDTH'(next_warp(int'(wid_q), NUM_WARPS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            isr_pc_q <= '0;
            wid_q    <= '0;
            tid_q    <= '0;
            mask_q   <= '0;
            pc_q     <= '0;
            rr_q     <= '0;
            att_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            isr_pc_q <= isr_pc_d;
            wid_q    <= wid_d;
            tid_q    <= tid_d;
            mask_q   <= mask_d;
            pc_q     <= pc_d;
            rr_q     <= rr_d;
            att_q    <= att_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = irq_valid ? DRAIN : IDLE;
            DRAIN:   state_d = hit  ? SWAP :
                               miss ? (last ? ABORT : DRAIN) :
                               timeout ? ABORT : DRAIN;
            SWAP:    state_d = RUN;
            RUN:     state_d = ttu.ISR_done ? RESTORE : RUN;
            RESTORE: state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        isr_pc_d = isr_pc_q;
        wid_d    = wid_q;
        tid_d    = tid_q;
        mask_d   = mask_q;
        pc_d     = pc_q;
        rr_d     = rr_q;
        att_d    = att_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE && irq_valid) begin
            isr_pc_d = irq_isr_pc;
            wid_d    = rr_q;
            att_d    = '0;
            cnt_d    = '0;
        end
        if (state_q == DRAIN) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (hit) begin
                mask_d = ttu.current_thread_mask;
                pc_d   = ttu.current_PC;
                tid_d  = low_idx;
            end else if (miss && !last) begin
                wid_d = wid_nxt;
                att_d = att_q + NW_WIDTH'(1);
                cnt_d = '0;
            end
        end
        if (state_q == RESTORE) rr_d = wid_nxt;
    end

    // irq_ready is gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        irq_ready = reset_n & (state_q == IDLE);
        irq_done  = state_q == RESTORE;
        irq_err   = state_q == ABORT;
    end

    assign ttu.state                   = state_q;
    assign ttu.ISR_PC                  = isr_pc_q;
    assign ttu.wid                     = wid_q;
    assign ttu.tid                     = tid_q;
    assign ttu.interrupted_thread_mask = mask_q;
    assign ttu.interrupted_PC          = pc_q;
endmodule

// File: tb/tb_vx_ttu_ctrl.sv
// tb_vx_ttu_ctrl: directed plus randomized check of vx_ttu_ctrl against a per-request warp-search model
module tb_vx_ttu_ctrl;
    import vx_ttu_ctrl_pkg::*;
    localparam int XLEN = 32, NW = 4, NT = 4, TO = 16;

    logic            clk = 0, reset_n = 0, irq_valid = 0;
    logic [XLEN-1:0] irq_isr_pc = '0;
    logic            irq_ready, irq_done, irq_err;
    int              checks = 0, errors = 0;
    int              rr_m = 0;

    bit              f_a [NW];
    logic [NT-1:0]   m_a [NW];
    logic [XLEN-1:0] p_a [NW];
    int              d_a [NW];

    vx_ttu_ctrl_if #(.XLEN(XLEN), .NUM_THREADS(NT), .NW_WIDTH(2), .NT_WIDTH(2)) ttu ();

    vx_ttu_ctrl #(.XLEN(XLEN), .NUM_WARPS(NW), .NUM_THREADS(NT), .DRAIN_TIMEOUT(TO), .CNT_W(11)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_valid  (irq_valid),
        .irq_isr_pc (irq_isr_pc),
        .irq_ready  (irq_ready),
        .irq_done   (irq_done),
        .irq_err    (irq_err),
        .ttu        (ttu.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setw(input int w, input bit f, input logic [NT-1:0] m, input logic [XLEN-1:0] p, input int d);
        f_a[w] = f; m_a[w] = m; p_a[w] = p; d_a[w] = d;
    endtask

    // One request from IDLE back to IDLE. Warps are visited from rr_m; a warp
    // hits when found with a nonzero mask, d_a >= TO means it never drains.
    task automatic do_irq(input logic [XLEN-1:0] pc, input int run_len, input bit bp, input logic [XLEN-1:0] bp_pc);
        int w = 0;
        int res = 0;
        logic [NT-1:0] lowbit;
        irq_valid = 1; irq_isr_pc = pc;
        chk("idle_state", ttu.state, IDLE);
        chk("idle_ready", irq_ready, 1);
        tick;
        irq_valid = 0;
        chk("isr_pc", ttu.ISR_PC, pc);
        for (int k = 0; k < NW && res == 0; k++) begin
            w = (rr_m + k) % NW;
            for (int c = 0; c < d_a[w] && c < TO; c++) begin
                chk("drain_state", ttu.state, DRAIN);
                chk("drain_wid", ttu.wid, w);
                chk("drain_ready", irq_ready, 0);
                ttu.ISR_done = 1'($urandom_range(0, 1));
                tick;
            end
            ttu.ISR_done = 0;
            if (d_a[w] >= TO) res = 2;
            else begin
                chk("resp_state", ttu.state, DRAIN);
                chk("resp_wid", ttu.wid, w);
                ttu.pipeline_drained = 1;
                ttu.thread_found = f_a[w];
                ttu.current_thread_mask = m_a[w];
                ttu.current_PC = p_a[w];
                tick;
                ttu.pipeline_drained = 0;
                ttu.thread_found = 0;
                ttu.current_thread_mask = $urandom;
                ttu.current_PC = $urandom;
                if (f_a[w] && m_a[w] != 0) res = 1;
                else if (k == NW - 1) res = 2;
            end
        end
        if (res == 2) begin
            chk("abort_state", ttu.state, ABORT);
            chk("abort_err", irq_err, 1);
            chk("abort_done", irq_done, 0);
            tick;
            chk("abort_idle", ttu.state, IDLE);
            chk("abort_err_low", irq_err, 0);
        end else begin
            lowbit = m_a[w] & (~m_a[w] + 1'b1);
            chk("swap_state", ttu.state, SWAP);
            chk("swap_wid", ttu.wid, w);
            chk("swap_tid", ttu.tid, $clog2(lowbit));
            chk("saved_mask", ttu.interrupted_thread_mask, m_a[w]);
            chk("saved_pc", ttu.interrupted_PC, p_a[w]);
            tick;
            for (int c = 0; c < run_len; c++) begin
                chk("run_state", ttu.state, RUN);
                chk("run_done", irq_done, 0);
                if (bp) begin irq_valid = 1; irq_isr_pc = bp_pc; end
                chk("run_ready", irq_ready, 0);
                tick;
                chk("run_isr_pc", ttu.ISR_PC, pc);
            end
            chk("run_last", ttu.state, RUN);
            ttu.ISR_done = 1;
            tick;
            ttu.ISR_done = 0;
            chk("restore_state", ttu.state, RESTORE);
            chk("restore_done", irq_done, 1);
            chk("restore_ready", irq_ready, 0);
            chk("restore_isr_pc", ttu.ISR_PC, pc);
            tick;
            chk("post_idle", ttu.state, IDLE);
            chk("post_done", irq_done, 0);
            rr_m = (w + 1) % NW;
        end
    endtask

    initial begin
        logic [XLEN-1:0] pc_cur, pc_nxt;
        bit bp;
        ttu.pipeline_drained = 0; ttu.thread_found = 0; ttu.ISR_done = 0;
        ttu.current_thread_mask = '0; ttu.current_PC = '0;
        for (int i = 0; i < NW; i++) setw(i, 0, '0, '0, 0);
        #1;
        chk("rst_state", ttu.state, IDLE);
        chk("rst_ready", irq_ready, 0);
        chk("rst_wid", ttu.wid, 0);
        chk("rst_isr_pc", ttu.ISR_PC, 0);
        tick; tick;
        reset_n = 1;
        tick;
        chk("rst_rel_ready", irq_ready, 1);
        chk("rst_rel_done", irq_done, 0);
        chk("rst_rel_err", irq_err, 0);

        setw(0, 1, 4'b1100, 32'h200, 5);
        do_irq(32'h8000_0100, 3, 1, 32'h8000_0200);
        setw(1, 1, 4'b0001, 32'h300, 0);
        do_irq(32'h8000_0200, 1, 0, '0);
        setw(2, 1, 4'b1000, 32'h400, 2);
        do_irq(32'h8000_0300, 0, 0, '0);
        setw(3, 0, 4'b1111, 32'h500, 1);
        setw(0, 1, 4'b0110, 32'h600, 3);
        do_irq(32'h8000_0400, 2, 0, '0);
        for (int i = 0; i < NW; i++) setw(i, 0, 4'b0101, 32'h700, i);
        setw(2, 1, 4'b0000, 32'h710, 1);
        do_irq(32'h8000_0500, 1, 0, '0);
        setw(1, 1, 4'b0010, 32'h800, TO);
        do_irq(32'h8000_0600, 1, 0, '0);

        pc_cur = $urandom;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NW; i++)
                setw(i, $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                     ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 15)));
            pc_nxt = $urandom;
            bp = 1'($urandom_range(0, 1));
            do_irq(pc_cur, int'($urandom_range(0, 5)), bp, pc_nxt);
            pc_cur = pc_nxt;
        end

        for (int i = 0; i < NW; i++) setw(i, 1, 4'b1010, 32'h900, 0);
        irq_valid = 1; irq_isr_pc = 32'hABCD_0000;
        tick;
        irq_valid = 0;
        ttu.pipeline_drained = 1; ttu.thread_found = 1;
        ttu.current_thread_mask = 4'b1010; ttu.current_PC = 32'h900;
        tick;
        ttu.pipeline_drained = 0; ttu.thread_found = 0;
        tick; tick;
        chk("pre_rst_run", ttu.state, RUN);
        #2 reset_n = 0;
        #1;
        chk("arst_state", ttu.state, IDLE);
        chk("arst_isr_pc", ttu.ISR_PC, 0);
        chk("arst_wid", ttu.wid, 0);
        chk("arst_tid", ttu.tid, 0);
        chk("arst_mask", ttu.interrupted_thread_mask, 0);
        chk("arst_pc", ttu.interrupted_PC, 0);
        chk("arst_ready", irq_ready, 0);
        chk("arst_done", irq_done, 0);
        chk("arst_err", irq_err, 0);
        ttu.ISR_done = 1;
        tick;
        chk("arst_hold_done", irq_done, 0);
        ttu.ISR_done = 0;
        reset_n = 1;
        rr_m = 0;
        tick;
        chk("arst_rel_done", irq_done, 0);
        do_irq(32'h1234_5678, 1, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
